// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD bus controller.
// Covers the FSM states, init ROM, command-register field positions and status bits.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } lcd_state_e;

    localparam int INIT_LEN = 6;
    // Entry 0 sits in the low byte: 0x38 x3, display on, clear, entry mode
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    localparam int DATA_LSB = 0;
    localparam int RS_BIT   = 8;
    localparam int BL_BIT   = 30;
    localparam int TOG_BIT  = 31;

    localparam int ST_BUSY    = 0;
    localparam int ST_INIT    = 1;
    localparam int ST_PENDING = 2;
    localparam int ST_OVERRUN = 3;

    function automatic int cnt_width(input int unsigned max_cyc);
        int w;
        w = $clog2(max_cyc);
        return (w < 20) ? 20 : w;
    endfunction

    // Clear/home instructions need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done_o is high on the final cycle of a loaded interval.
// Loading N-1 gives an interval of exactly N cycles.
module lcd_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             run_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

    assign run_o  = run_q;
    assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Turns toggle-flagged 32-bit LCD register writes into HD44780 8-bit write cycles,
// running the power-up init sequence first and buffering one early command.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP_CYC = 750000,
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 4,
    parameter int unsigned T_EXEC_CYC  = 2500,
    parameter int unsigned T_CLEAR_CYC = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_reg_i,
    output logic [31:0] status_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o
);

    localparam int unsigned MAX_A   = (T_PWRUP_CYC > T_CLEAR_CYC) ? T_PWRUP_CYC : T_CLEAR_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > T_EXEC_CYC) ? MAX_A : T_EXEC_CYC;
    localparam int          CNT_W   = cnt_width(MAX_CYC);

    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic             reg_tog_q, reg_bl_q, reg_rs_q;
    logic [7:0]       reg_data_q;
    logic             last_tog_q, new_cmd, direct;
    logic [8:0]       det_cmd, ld_cmd, pend_cmd_q;
    logic             pend_vld_q, push, pop;
    logic             init_done_q, init_set, overrun_q, ovr_set;
    logic [2:0]       idx_q, idx_d;
    logic             ld_en, exec_long_q, blon_q;
    logic             tmr_load, tmr_run, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             unused_bits;

    assign unused_bits = ^lcd_reg_i[29:9];

    lcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .run_o      (tmr_run),
        .done_o     (tmr_done)
    );

    assign new_cmd = (reg_tog_q != last_tog_q);
    assign det_cmd = {reg_rs_q, reg_data_q};
    assign direct  = (state_q == S_IDLE) && !pend_vld_q && new_cmd;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        ld_en    = 1'b0;
        ld_cmd   = pend_cmd_q;
        pop      = 1'b0;
        push     = 1'b0;
        ovr_set  = 1'b0;
        init_set = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (tmr_done) begin
                    state_d = S_LOAD;
                    idx_d   = 3'd0;
                    ld_en   = 1'b1;
                    ld_cmd  = {1'b0, INIT_ROM[0]};
                end else if (!tmr_run) begin
                    tmr_load = 1'b1;
                    tmr_val  = PWRUP_LD;
                end
            end
            S_LOAD: begin
                state_d  = S_SETUP;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            S_SETUP: if (tmr_done) begin
                state_d  = S_EN;
                tmr_load = 1'b1;
                tmr_val  = EN_LD;
            end
            S_EN: if (tmr_done) begin
                state_d  = S_HOLD;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            S_HOLD: if (tmr_done) begin
                state_d  = S_WAIT;
                tmr_load = 1'b1;
                tmr_val  = exec_long_q ? CLEAR_LD : EXEC_LD;
            end
            S_WAIT: if (tmr_done) begin
                if (init_done_q) begin
                    state_d = S_IDLE;
                end else if (idx_q == 3'(INIT_LEN - 1)) begin
                    state_d  = S_IDLE;
                    init_set = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    idx_d   = idx_q + 3'd1;
                    ld_en   = 1'b1;
                    ld_cmd  = {1'b0, INIT_ROM[idx_d]};
                end
            end
            S_IDLE: begin
                if (pend_vld_q) begin
                    state_d = S_LOAD;
                    pop     = 1'b1;
                    ld_en   = 1'b1;
                    ld_cmd  = pend_cmd_q;
                end else if (new_cmd) begin
                    state_d = S_LOAD;
                    ld_en   = 1'b1;
                    ld_cmd  = det_cmd;
                end
            end
            default: state_d = S_PWRUP;
        endcase
        // Anything not launched straight from idle goes to the single-entry buffer
        if (new_cmd && !direct) begin
            if (pend_vld_q && !pop) ovr_set = 1'b1;
            else                    push    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_PWRUP;
            reg_tog_q   <= 1'b0;
            reg_bl_q    <= 1'b0;
            reg_rs_q    <= 1'b0;
            reg_data_q  <= '0;
            last_tog_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_cmd_q  <= '0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            idx_q       <= '0;
            exec_long_q <= 1'b0;
            lcd_data_o  <= '0;
            lcd_rs_o    <= 1'b0;
            blon_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_tog_q  <= lcd_reg_i[TOG_BIT];
            reg_bl_q   <= lcd_reg_i[BL_BIT];
            reg_rs_q   <= lcd_reg_i[RS_BIT];
            reg_data_q <= lcd_reg_i[DATA_LSB +: 8];
            blon_q     <= reg_bl_q;
            idx_q      <= idx_d;
            if (new_cmd)  last_tog_q  <= reg_tog_q;
            if (init_set) init_done_q <= 1'b1;
            if (ovr_set)  overrun_q   <= 1'b1;
            if (push) begin
                pend_vld_q <= 1'b1;
                pend_cmd_q <= det_cmd;
            end else if (pop) begin
                pend_vld_q <= 1'b0;
            end
            if (ld_en) begin
                lcd_rs_o    <= ld_cmd[8];
                lcd_data_o  <= ld_cmd[7:0];
                exec_long_q <= is_long_cmd(ld_cmd[8], ld_cmd[7:0]);
            end
        end
    end

    always_comb begin
        status_o             = '0;
        status_o[ST_BUSY]    = (state_q != S_IDLE);
        status_o[ST_INIT]    = init_done_q;
        status_o[ST_PENDING] = pend_vld_q;
        status_o[ST_OVERRUN] = overrun_q;
    end

    assign lcd_en_o   = (state_q == S_EN);
    assign lcd_rw_o   = 1'b0;
    assign lcd_on_o   = 1'b1;
    assign lcd_blon_o = blon_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed sequence plus random writes, with an EN-pulse monitor
// comparing every bus cycle against an expected transfer queue.
module tb_lcd_ctrl;

    localparam int PWRUP = 20, SETUP = 2, EN = 4, HOLD = 2, EXEC = 10, CLEAR = 30;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] lcd_reg_i = '0;
    logic [31:0] status_o;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;

    lcd_ctrl #(
        .T_PWRUP_CYC (PWRUP), .T_SETUP_CYC (SETUP), .T_EN_CYC (EN),
        .T_HOLD_CYC  (HOLD),  .T_EXEC_CYC  (EXEC),  .T_CLEAR_CYC (CLEAR)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .lcd_reg_i  (lcd_reg_i),
        .status_o   (status_o),
        .lcd_data_o (lcd_data_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_on_o   (lcd_on_o),
        .lcd_blon_o (lcd_blon_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk_i) cyc++;

    logic [7:0] INIT_SEQ [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [8:0] exp_q [$];
    logic       tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Low cycles from EN fall to next EN rise when the next command is ready at once
    function automatic int min_gap(input logic [8:0] c);
        int w;
        w = (!c[8] && c[7:2] == 6'd0) ? CLEAR : EXEC;
        return HOLD + w + 1 + SETUP;
    endfunction

    task automatic write_cmd(input logic rs, input logic [7:0] d, input logic bl);
        tog = ~tog;
        lcd_reg_i = {tog, bl, 21'd0, rs, d};
    endtask

    task automatic wait_status(input logic [31:0] want, input int budget, input string tag);
        for (int i = 0; i < budget && status_o !== want; i++) @(negedge clk_i);
        chk(tag, status_o, want);
    endtask

    task automatic push_init();
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, INIT_SEQ[i]});
    endtask

    // EN-pulse monitor
    int         pulse_cnt = 0, width = 0, low_cnt = 0, gap_min = 0, first_rise = 0;
    logic       in_pulse = 1'b0, have_prev = 1'b0;
    logic [8:0] rise_cmd, exp_cmd;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            in_pulse  = 1'b0;
            have_prev = 1'b0;
            pulse_cnt = 0;
            width     = 0;
            low_cnt   = 0;
        end else if (lcd_en_o) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                width    = 1;
                pulse_cnt++;
                if (pulse_cnt == 1) first_rise = cyc;
                rise_cmd = {lcd_rs_o, lcd_data_o};
                exp_cmd  = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
                chk("en_cmd", 32'(rise_cmd), 32'(exp_cmd));
                if (have_prev) chk("en_gap", 32'(low_cnt >= gap_min), 32'd1);
            end else begin
                width++;
            end
        end else begin
            if (in_pulse) begin
                in_pulse  = 1'b0;
                have_prev = 1'b1;
                chk("en_width", 32'(width), 32'(EN));
                chk("hold_data", 32'({lcd_rs_o, lcd_data_o}), 32'(rise_cmd));
                gap_min = min_gap(rise_cmd);
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
        end
    end

    int         rel_cyc, busy_cnt;
    logic       r_rs;
    logic [7:0] r_d;

    initial begin
        rst_ni = 1'b0;
        lcd_reg_i = '0;
        tog = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_status", status_o, 32'h1);
        chk("rst_en", 32'(lcd_en_o), 32'd0);
        chk("rst_data", 32'(lcd_data_o), 32'd0);
        chk("rst_rs", 32'(lcd_rs_o), 32'd0);
        chk("rst_rw", 32'(lcd_rw_o), 32'd0);
        chk("rst_on", 32'(lcd_on_o), 32'd1);
        chk("rst_blon", 32'(lcd_blon_o), 32'd0);

        // Autonomous init
        push_init();
        rst_ni = 1'b1;
        rel_cyc = cyc;
        wait_status(32'h2, 1000, "init_done");
        chk("init_pulses", 32'(pulse_cnt), 32'd6);
        chk("init_q_empty", 32'(exp_q.size()), 32'd0);
        chk("pwrup_delay", 32'((first_rise - rel_cyc) >= PWRUP), 32'd1);

        // Single data write 'A': latency and busy window
        write_cmd(1'b1, 8'h41, 1'b0);
        chk("A_word", lcd_reg_i, 32'h8000_0141);
        exp_q.push_back(9'h141);
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (status_o[0]) busy_cnt++;
            if (k == 4) chk("lat_en_low", 32'(lcd_en_o), 32'd0);
            if (k == 5) begin
                chk("lat_en_high", 32'(lcd_en_o), 32'd1);
                chk("A_data", 32'(lcd_data_o), 32'h41);
                chk("A_rs", 32'(lcd_rs_o), 32'd1);
            end
        end
        chk("A_busy_cycles", 32'(busy_cnt), 32'd19);
        chk("A_status", status_o, 32'h2);

        // Random writes, each allowed to complete
        for (int i = 0; i < 7; i++) begin
            r_rs = 1'($urandom_range(0, 1));
            r_d  = 8'($urandom_range(0, 255));
            write_cmd(r_rs, r_d, 1'b0);
            exp_q.push_back({r_rs, r_d});
            repeat (3) @(negedge clk_i);
            wait_status(32'h2, 200, "rand_idle");
        end
        chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_pulses", 32'(pulse_cnt), 32'd14);

        // Same toggle, new data: no transfer
        lcd_reg_i = {tog, 1'b0, 21'd0, 1'b1, 8'h5A};
        repeat (40) @(negedge clk_i);
        chk("same_tog_pulses", 32'(pulse_cnt), 32'd14);
        chk("same_tog_status", status_o, 32'h2);

        // Backlight only
        lcd_reg_i = {tog, 1'b1, 30'd0};
        chk("bl_word", lcd_reg_i, 32'h4000_0000);
        repeat (2) @(negedge clk_i);
        chk("blon", 32'(lcd_blon_o), 32'd1);
        repeat (20) @(negedge clk_i);
        chk("blon_no_en", 32'(pulse_cnt), 32'd14);

        // Pending buffer and overrun during init
        lcd_reg_i = '0;
        tog = 1'b0;
        rst_ni = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        push_init();
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("pre_pend", status_o, 32'h1);
        write_cmd(1'b1, 8'h55, 1'b0);
        exp_q.push_back(9'h155);
        repeat (3) @(negedge clk_i);
        chk("pend_set", status_o, 32'h5);
        write_cmd(1'b1, 8'h66, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("overrun_set", status_o, 32'hD);
        wait_status(32'hA, 1000, "pend_drained");
        chk("pend_pulses", 32'(pulse_cnt), 32'd7);
        chk("pend_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of an EN pulse
        write_cmd(1'b0, 8'h80, 1'b0);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 50 && !lcd_en_o; i++) @(negedge clk_i);
        chk("en_before_rst", 32'(lcd_en_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        lcd_reg_i = '0;
        tog = 1'b0;
        #1;
        chk("rst_en_async", 32'(lcd_en_o), 32'd0);
        chk("rst_status_async", status_o, 32'h1);
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        push_init();
        rst_ni = 1'b1;
        wait_status(32'h2, 1000, "reinit_done");
        chk("reinit_pulses", 32'(pulse_cnt), 32'd6);
        chk("reinit_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Peripheral-side consumer of the memory-mapped LCD output register: turns 32-bit command words written by the CPU into HD44780-compatible 8-bit bus cycles.
- Sits between the data-memory LCD register output and the board LCD pins.
- Runs the controller power-up init sequence autonomously.
- Returns a status word that the top level routes onto a readable input-peripheral address.

Parameters:
- T_PWRUP_CYC, 750000: cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_SETUP_CYC, 4: cycles RS/DATA are stable before EN rises.
- T_EN_CYC, 12: cycles EN is held high.
- T_HOLD_CYC, 4: cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2500: execution wait for normal commands and data (50 us).
- T_CLEAR_CYC, 82000: execution wait for clear/home commands (1.64 ms).

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- lcd_reg_i, in, 32: LCD register value from data memory. Fields: [7:0] data; [8] rs; [30] backlight; [31] command toggle.
- status_o, out, 32: status word. [0] busy; [1] init_done; [2] pending; [3] overrun; [31:4] zero.
- lcd_data_o, out, 8: LCD data bus.
- lcd_rs_o, out, 1: register select.
- lcd_rw_o, out, 1: read/write; constant 0 (write only).
- lcd_en_o, out, 1: enable strobe.
- lcd_on_o, out, 1: LCD power.
- lcd_blon_o, out, 1: backlight.

Behaviour:
- Reset values:
  - lcd_data_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_on_o=1, lcd_blon_o=0.
  - status_o=32'h1 (busy).
  - last_tog=0, pending buffer empty, overrun=0, state=S_PWRUP, all counters 0.
  - Reset asserted mid-transfer aborts immediately: EN drops asynchronously and the init sequence restarts from S_PWRUP.
- Command detection:
  - A new command is lcd_reg_i[31] != last_tog, compared against a registered copy of lcd_reg_i.
  - On detection, last_tog is updated and {rs, data} is captured.
  - Software starts with toggle=1 and flips bit 31 on every write.
- Pending buffer (1 entry):
  - In S_IDLE with init_done=1, a detected command is launched directly.
  - Otherwise it is stored in the pending buffer.
  - If the buffer is full, the command is dropped and overrun sets. overrun stays set until reset.
  - The pending entry is launched on the first S_IDLE cycle after init_done.
- lcd_blon_o tracks registered lcd_reg_i[30] at all times, independent of the FSM.
- Init ROM, 6 entries, rs=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- FSM states:
  - S_PWRUP: count T_PWRUP_CYC cycles, then go to S_LOAD.
  - S_LOAD (1 cycle):
    - Drive data/rs from the ROM during init, otherwise from the captured command.
    - Select the wait time: T_CLEAR_CYC if rs=0 and data[7:2]==0 (0x01..0x03), else T_EXEC_CYC.
    - Go to S_SETUP.
  - S_SETUP: T_SETUP_CYC cycles, then S_EN.
  - S_EN: lcd_en_o=1 for exactly T_EN_CYC cycles, then S_HOLD.
  - S_HOLD: T_HOLD_CYC cycles, data/rs unchanged, then S_WAIT.
  - S_WAIT: selected exec cycles.
    - During init: advance the ROM index. After index 5, set init_done and go to S_IDLE; otherwise go to S_LOAD.
    - After init: go to S_IDLE.
  - S_IDLE:
    - busy=0.
    - If a pending entry exists, pop it and go to S_LOAD.
    - Else, on a detected command, capture it and go to S_LOAD in the next cycle.
    - A pending pop and a new detection in the same cycle: the new command is pushed into the buffer.
- lcd_data_o/lcd_rs_o are registered and change only on entry to S_LOAD.
- Latency from a toggle flip to EN rising in idle is 1 (input register) + 1 (detect) + 1 (S_LOAD) + T_SETUP_CYC cycles.
- busy = (state != S_IDLE). pending = buffer valid.
- Counters are sized for the largest parameter (≥20 bits). Terminal count is param-1; no wrap beyond that.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum lcd_state_e;
  - init ROM constant array and its length;
  - register field index constants (DATA_LSB, RS_BIT, BL_BIT, TOG_BIT);
  - status bit indices.
- One sub-module, lcd_timer: loadable down-counter with a done pulse, reused for all timing phases.

Test Plan (params: PWRUP=20, SETUP=2, EN=4, HOLD=2, EXEC=10, CLEAR=30):
- Reset, then idle input:
  - Six EN pulses, each 4 cycles wide, carrying data 38, 38, 38, 0C, 01, 06 with rs=0.
  - The gap after 0x01 is ≥30 cycles.
  - status_o becomes 32'h2 after the last wait.
- After init, write 32'h8000_0141 (toggle 1, rs 1, 'A'):
  - EN rises 3+2 cycles after the write.
  - lcd_data_o=0x41, rs=1.
  - busy for 1+2+4+2+10 cycles.
  - status_o returns to 32'h2.
- During init, write cmd1 then cmd2 (toggle flips twice):
  - cmd1 goes into the pending buffer (status bit 2=1).
  - cmd2 sets overrun (status bit 3).
  - After init, only cmd1 is issued.
- Write the same toggle value twice with different data: no second transfer.
- Write 32'h4000_0000 (backlight, toggle unchanged): lcd_blon_o=1 two cycles later, no EN pulse.
- Assert rst_ni while lcd_en_o=1: EN=0 immediately, status_o=1, and the init sequence restarts from the start.
